// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline stall controller for the 5-stage core.
// Merges the ID load-use stall request with sequencing of the shared
// multi-cycle mul/div unit, drives the IF/ID/EX/MEM/WB stall bus and
// issues start pulses to the mul/div unit.
// Optional watchdog: define PIPE_STALL_CTRL_TIMEOUT_EN to force completion
// after MD_TIMEOUT WAIT cycles and raise the sticky md_timeout flag.
module pipe_stall_ctrl #(
  parameter int unsigned STALL_W    = 6,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned PERF_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               md_req,
  input  logic [1:0]         md_op,
  input  logic               md_done,
  output logic               md_start,
  output logic [1:0]         md_op_o,
  output logic               md_result_valid,
  output logic               md_busy,
  output logic               md_timeout,
  output logic [STALL_W-1:0] stall,
  output logic [PERF_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  // The watchdog compare value must fit the wait counter.
  if (64'(MD_TIMEOUT) > (64'd1 << CNT_W)) begin : g_bad_timeout
    $error("pipe_stall_ctrl: MD_TIMEOUT exceeds 2**CNT_W");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [PERF_W-1:0]  perf_q, perf_d;
  logic               md_hold;

`ifdef PIPE_STALL_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MD_TIMEOUT - 1);
  logic to_q, to_d;
`endif

  // Next-state logic for the mul/div sequencer, wait counter and latched op.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
`ifdef PIPE_STALL_CTRL_TIMEOUT_EN
    to_d    = to_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (md_req) begin
          state_d = S_START;
          op_d    = md_op;
          cnt_d   = '0;
        end
      end
      S_START: begin
        state_d = md_done ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (md_done) begin
          state_d = S_DONE;
`ifdef PIPE_STALL_CTRL_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          state_d = S_DONE;
          to_d    = 1'b1;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stall bus: mul/div hold outranks the load-use bubble; forced to 0 in reset.
  always_comb begin
    md_hold = ((state_q == S_IDLE) && md_req) ||
              (state_q == S_START) || (state_q == S_WAIT);
    stall = '0;
    if (rst) begin
      if (md_hold) begin
        stall[3:0] = 4'b1111;
      end else if (stallreq_id) begin
        stall[2:0] = 3'b111;
      end
    end
  end

  // Stall-cycle performance counter, free-running with wrap.
  always_comb begin
    perf_d = perf_q;
    if (stall[0]) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      perf_q  <= '0;
`ifdef PIPE_STALL_CTRL_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      perf_q  <= perf_d;
`ifdef PIPE_STALL_CTRL_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign md_start        = (state_q == S_START);
  assign md_result_valid = (state_q == S_DONE);
  assign md_busy         = (state_q != S_IDLE);
  assign md_op_o         = op_q;
  assign stall_cycles    = perf_q;

`ifdef PIPE_STALL_CTRL_TIMEOUT_EN
  assign md_timeout = to_q;
`else
  assign md_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: a vector table, directed
// multi-cycle sequences and randomized stimulus checked against a
// transaction-level reference model.
module tb_pipe_stall_ctrl;

  localparam int unsigned MD_TIMEOUT = 40;
`ifdef PIPE_STALL_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        md_req;
  logic [1:0]  md_op;
  logic        md_done;
  logic        md_start;
  logic [1:0]  md_op_o;
  logic        md_result_valid;
  logic        md_busy;
  logic        md_timeout;
  logic [5:0]  stall;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .STALL_W   (6),
    .CNT_W     (6),
    .MD_TIMEOUT(MD_TIMEOUT),
    .PERF_W    (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id    (stallreq_id),
    .md_req         (md_req),
    .md_op          (md_op),
    .md_done        (md_done),
    .md_start       (md_start),
    .md_op_o        (md_op_o),
    .md_result_valid(md_result_valid),
    .md_busy        (md_busy),
    .md_timeout     (md_timeout),
    .stall          (stall),
    .stall_cycles   (stall_cycles)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: an operation is "in flight" from acceptance until the
  // unit reports (or the watchdog forces) completion; the following cycle is
  // the result cycle. age counts cycles since the start pulse.
  bit          m_inflight;
  bit          m_result;
  int unsigned m_age;
  logic [1:0]  m_op;
  bit          m_to;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [5:0] exp_stall();
    if (m_inflight || (!m_result && md_req)) return 6'b001111;
    if (stallreq_id) return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    m_inflight = 1'b0;
    m_result   = 1'b0;
    m_age      = 0;
    m_op       = 2'b00;
    m_to       = 1'b0;
    m_cnt      = 32'd0;
  endtask

  task automatic check_model();
    chk("m_stall",  32'(stall),           32'(exp_stall()));
    chk("m_start",  32'(md_start),        32'(m_inflight && m_age == 0));
    chk("m_busy",   32'(md_busy),         32'(m_inflight || m_result));
    chk("m_valid",  32'(md_result_valid), 32'(m_result));
    chk("m_op_o",   32'(md_op_o),         32'(m_op));
    chk("m_tmo",    32'(md_timeout),      32'(m_to));
    chk("m_cycles", stall_cycles,         m_cnt);
  endtask

  // Step model across one rising edge using the inputs held across it.
  task automatic advance();
    logic [5:0] s;
    s = exp_stall();
    @(posedge clk);
    if (s[0]) m_cnt = m_cnt + 32'd1;
    if (m_result) begin
      m_result = 1'b0;
    end else if (m_inflight) begin
      if (md_done) begin
        m_inflight = 1'b0;
        m_result   = 1'b1;
      end else if (TO_EN && m_age == MD_TIMEOUT) begin
        m_inflight = 1'b0;
        m_result   = 1'b1;
        m_to       = 1'b1;
      end else begin
        m_age++;
      end
    end else if (md_req) begin
      m_inflight = 1'b1;
      m_age      = 0;
      m_op       = md_op;
    end
    @(negedge clk);
  endtask

  task automatic apply(input logic r, input logic [1:0] o, input logic d, input logic s);
    md_req = r; md_op = o; md_done = d; stallreq_id = s;
    #1;
  endtask

  task automatic cyc(input logic r, input logic [1:0] o, input logic d, input logic s);
    apply(r, o, d, s);
    check_model();
    advance();
  endtask

  task automatic do_reset();
    md_req = 1'b0; md_op = 2'b00; md_done = 1'b0; stallreq_id = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        req;
    logic [1:0]  op;
    logic        done;
    logic        sid;
    logic [5:0]  stall;
    logic        start;
    logic        valid;
    logic        busy;
    logic [1:0]  op_o;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int starts;
    int nwait;

    // 1-cycle unit, back-to-back ops, ignored md_done/md_req, load-use bubble.
    tbl[0]  = '{1'b1, 2'b01, 1'b0, 1'b0, 6'b001111, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0};
    tbl[1]  = '{1'b1, 2'b01, 1'b1, 1'b0, 6'b001111, 1'b1, 1'b0, 1'b1, 2'b01, 32'd1};
    tbl[2]  = '{1'b1, 2'b01, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b1, 2'b01, 32'd2};
    tbl[3]  = '{1'b1, 2'b11, 1'b0, 1'b0, 6'b001111, 1'b0, 1'b0, 1'b0, 2'b01, 32'd2};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 1'b0, 6'b001111, 1'b1, 1'b0, 1'b1, 2'b11, 32'd3};
    tbl[5]  = '{1'b0, 2'b00, 1'b1, 1'b1, 6'b001111, 1'b0, 1'b0, 1'b1, 2'b11, 32'd4};
    tbl[6]  = '{1'b0, 2'b00, 1'b0, 1'b1, 6'b000111, 1'b0, 1'b1, 1'b1, 2'b11, 32'd5};
    tbl[7]  = '{1'b0, 2'b00, 1'b0, 1'b1, 6'b000111, 1'b0, 1'b0, 1'b0, 2'b11, 32'd6};
    tbl[8]  = '{1'b0, 2'b00, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 2'b11, 32'd7};
    tbl[9]  = '{1'b0, 2'b00, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 2'b11, 32'd7};
    tbl[10] = '{1'b0, 2'b00, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 2'b11, 32'd7};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 1'b1, 6'b000111, 1'b0, 1'b0, 1'b0, 2'b11, 32'd7};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 2'b11, 32'd8};

    md_req = 1'b0; md_op = 2'b00; md_done = 1'b0; stallreq_id = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Reset values
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy",  32'(md_busy), 32'd0);
    chk("rst_cycles", stall_cycles, 32'd0);
    chk("rst_op_o",  32'(md_op_o), 32'd0);
    chk("rst_tmo",   32'(md_timeout), 32'd0);
    rst = 1'b1;
    model_reset();

    // Vector table
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].req, tbl[i].op, tbl[i].done, tbl[i].sid);
      chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].stall));
      chk($sformatf("tbl%0d_start", i), 32'(md_start), 32'(tbl[i].start));
      chk($sformatf("tbl%0d_valid", i), 32'(md_result_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_busy", i), 32'(md_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_op_o", i), 32'(md_op_o), 32'(tbl[i].op_o));
      chk($sformatf("tbl%0d_cycles", i), stall_cycles, tbl[i].cnt);
      check_model();
      advance();
    end

    // div with md_done 33 cycles after md_start
    do_reset();
    starts = 0;
    apply(1'b1, 2'b10, 1'b0, 1'b0);
    chk("div_req_stall", 32'(stall), 32'(6'b001111));
    check_model();
    advance();
    for (int k = 1; k <= 34; k++) begin
      apply(1'b1, 2'b10, (k == 34), 1'b0);
      if (md_start) starts++;
      chk("div_hold_stall", 32'(stall), 32'(6'b001111));
      check_model();
      advance();
    end
    apply(1'b0, 2'b00, 1'b0, 1'b0);
    chk("div_starts", 32'(starts), 32'd1);
    chk("div_valid", 32'(md_result_valid), 32'd1);
    chk("div_done_stall", 32'(stall), 32'd0);
    chk("div_op_o", 32'(md_op_o), 32'(2'b10));
    chk("div_cycles", stall_cycles, 32'd35);
    check_model();
    advance();
    apply(1'b0, 2'b00, 1'b0, 1'b0);
    chk("div_valid_once", 32'(md_result_valid), 32'd0);
    check_model();
    advance();

    // Load-use together with mul/div request
    apply(1'b1, 2'b00, 1'b0, 1'b1);
    chk("both_stall", 32'(stall), 32'(6'b001111));
    check_model();
    advance();
    cyc(1'b1, 2'b00, 1'b0, 1'b1);
    cyc(1'b1, 2'b00, 1'b0, 1'b1);
    cyc(1'b1, 2'b00, 1'b1, 1'b1);
    apply(1'b1, 2'b00, 1'b0, 1'b1);
    chk("both_done_stall", 32'(stall), 32'(6'b000111));
    chk("both_done_valid", 32'(md_result_valid), 32'd1);
    check_model();
    advance();
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);

    // Long wait: watchdog fires, or counter saturates without one
    do_reset();
    nwait = TO_EN ? int'(MD_TIMEOUT) : 70;
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    for (int k = 0; k < nwait; k++) begin
      apply(1'b1, 2'b11, 1'b0, 1'b0);
      chk("wait_busy", 32'(md_busy), 32'd1);
      check_model();
      advance();
    end
    if (!TO_EN) begin
      apply(1'b1, 2'b11, 1'b0, 1'b0);
      chk("nowd_busy", 32'(md_busy), 32'd1);
      chk("nowd_tmo", 32'(md_timeout), 32'd0);
      check_model();
      advance();
      cyc(1'b1, 2'b11, 1'b1, 1'b0);
    end
    apply(1'b0, 2'b00, 1'b0, 1'b0);
    chk("long_valid", 32'(md_result_valid), 32'd1);
    chk("long_tmo", 32'(md_timeout), 32'(TO_EN));
    check_model();
    advance();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 2'b00, 1'b0, 1'b0);
      chk("tmo_sticky", 32'(md_timeout), 32'(TO_EN));
      check_model();
      advance();
    end

    // Reset asserted mid-operation with md_req held high
    do_reset();
    cyc(1'b1, 2'b01, 1'b0, 1'b1);
    cyc(1'b1, 2'b01, 1'b0, 1'b1);
    cyc(1'b1, 2'b01, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_start", 32'(md_start), 32'd0);
    chk("arst_busy", 32'(md_busy), 32'd0);
    chk("arst_valid", 32'(md_result_valid), 32'd0);
    chk("arst_cycles", stall_cycles, 32'd0);
    chk("arst_op_o", 32'(md_op_o), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_busy", 32'(md_busy), 32'd0);
    chk("arst_hold_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0);

    // Randomized stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
